// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg : shared CPU types and widths used by fetch, ROM and decode.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int CPU_ADDR_W  = 11;
    localparam int CPU_DATA_W  = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_next_pc.sv
//------------------------------------------------------------------------------
// fetch_next_pc : combinational ROM address select and sequential increment.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  fetch_state_t      state,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic [ADDR_W-1:0] resp_pc,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] next_fetch_pc,
    output logic              misaligned,
    output logic              stop
);

    logic aligned;

    always_comb begin
        aligned       = is_aligned(redirect_pc[1:0]);
        misaligned    = 1'b0;
        stop          = 1'b0;
        rom_addr      = resp_pc;

        case (state)
            ST_BOOT: rom_addr = fetch_pc;
            ST_RUN: begin
                // Halt outranks redirect; a bad target is never issued.
                if (halt_req) begin
                    rom_addr = resp_pc;
                    stop     = 1'b1;
                end else if (redirect_valid) begin
                    if (aligned) begin
                        rom_addr = redirect_pc;
                    end else begin
                        rom_addr   = resp_pc;
                        misaligned = 1'b1;
                        stop       = 1'b1;
                    end
                end else if (stall) begin
                    rom_addr = resp_pc;
                end else begin
                    rom_addr = fetch_pc;
                end
            end
            default: rom_addr = resp_pc;
        endcase

        next_fetch_pc = rom_addr + ADDR_W'(INSTR_BYTES);
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit : PC owner for the instruction ROM; pairs returned words with PC.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              aclr_n,
    output logic              rom_aclr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted,
    output logic              misalign_err
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic              err;
    logic [ADDR_W-1:0] next_fetch_pc;
    logic              misaligned;
    logic              stop;

    fetch_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .state          (state),
        .fetch_pc       (fetch_pc),
        .resp_pc        (resp_pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .rom_addr       (rom_addr),
        .next_fetch_pc  (next_fetch_pc),
        .misaligned     (misaligned),
        .stop           (stop)
    );

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN:  if (stop) state_nxt = ST_HALT;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_BOOT;
        endcase
    end

    // resp_pc tracks the address the ROM has latched, so instr_pc lines up with rom_dout.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    resp_pc  <= RESET_PC;
                    fetch_pc <= RESET_PC + ADDR_W'(INSTR_BYTES);
                end
                ST_RUN: begin
                    resp_pc  <= rom_addr;
                    fetch_pc <= next_fetch_pc;
                    if (misaligned) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    resp_pc  <= resp_pc;
                    fetch_pc <= fetch_pc;
                end
            endcase
        end
    end

    assign rom_aclr     = ~aclr_n;
    assign instr        = rom_dout;
    assign instr_pc     = resp_pc;
    assign instr_valid  = (state == ST_RUN);
    assign halted       = (state == ST_HALT);
    assign misalign_err = err;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_fetch_unit : fetch_unit with a registered-address ROM model and PC scoreboard.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk;
    logic              aclr_n;
    logic              rom_aclr;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              halted;
    logic              misalign_err;

    int n_vec;
    int n_err;
    logic [ADDR_W-1:0] exp_q[$];

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (11'h0)
    ) dut (
        .clk            (clk),
        .aclr_n         (aclr_n),
        .rom_aclr       (rom_aclr),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    // ROM: word[i] = A000_0000 + i, decodes addr[9:2], registered address.
    logic [ADDR_W-1:0] rom_q;
    always_ff @(posedge clk or posedge rom_aclr) begin
        if (rom_aclr) rom_q <= '0;
        else          rom_q <= rom_addr;
    end
    assign rom_dout = 32'hA000_0000 + {24'd0, rom_q[9:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] pc);
        exp_q.push_back(pc);
    endtask

    // Scoreboard consumer: every valid cycle must match the next expected PC.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] pc;
        if (aclr_n && instr_valid) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                pc = exp_q.pop_front();
                check("instr_pc", 32'(instr_pc), 32'(pc));
                check("instr", instr, 32'hA000_0000 + {24'd0, pc[9:2]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        aclr_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt_req = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(misalign_err), 32'd0);
        check("rst_rom_aclr", 32'(rom_aclr), 32'd1);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);

        // Release; BOOT cycle then sequential fetch
        @(posedge clk); #1;
        aclr_n = 1'b1;
        #4;
        check("boot_valid", 32'(instr_valid), 32'd0);
        check("boot_rom_aclr", 32'(rom_aclr), 32'd0);
        push(11'h000); tick();
        push(11'h004); tick();
        push(11'h008); tick();

        // Stall three cycles at 0x08
        stall = 1'b1;
        push(11'h008); tick();
        push(11'h008); tick();
        push(11'h008); tick();
        stall = 1'b0;
        push(11'h00C); tick();
        push(11'h010); tick();

        // Redirect beats stall at 0x10
        redirect_valid = 1'b1;
        redirect_pc = 11'h040;
        stall = 1'b1;
        push(11'h040); tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        push(11'h044); tick();

        // Redirect to top of address space, wraps to 0
        redirect_valid = 1'b1;
        redirect_pc = 11'h7FC;
        push(11'h7FC); tick();
        redirect_valid = 1'b0;
        push(11'h000); tick();
        push(11'h004); tick();
        push(11'h008); tick();
        push(11'h00C); tick();

        // Halt at 0x0C, with a redirect that must be ignored
        halt_req = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 11'h100;
        tick();
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("sb_drain1", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_rom_addr", 32'(rom_addr), 32'h00C);
            check("halt_err", 32'(misalign_err), 32'd0);
            @(negedge clk);
        end

        // Async reset pulse returns to BOOT
        #2;
        aclr_n = 1'b0;
        #1;
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_rom_aclr", 32'(rom_aclr), 32'd1);
        @(posedge clk); #1;
        aclr_n = 1'b1;
        push(11'h000); tick();
        push(11'h004); tick();

        // Misaligned redirect at 0x04
        redirect_valid = 1'b1;
        redirect_pc = 11'h042;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_halted", 32'(halted), 32'd1);
        check("mis_valid", 32'(instr_valid), 32'd0);
        check("mis_rom_addr", 32'(rom_addr), 32'h004);
        check("sb_drain2", 32'(exp_q.size()), 32'd0);

        // Reset clears sticky error; then async reset mid-run
        @(posedge clk); #1;
        aclr_n = 1'b0;
        #1;
        check("clr_err", 32'(misalign_err), 32'd0);
        @(posedge clk); #1;
        aclr_n = 1'b1;
        push(11'h000); tick();
        push(11'h004); tick();
        push(11'h008); tick();
        @(negedge clk); #1;
        check("sb_drain3", 32'(exp_q.size()), 32'd0);
        aclr_n = 1'b0;
        #1;
        check("mid_valid", 32'(instr_valid), 32'd0);
        check("mid_instr_pc", 32'(instr_pc), 32'd0);
        check("mid_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_halted", 32'(halted), 32'd0);
        check("mid_rom_aclr", 32'(rom_aclr), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
